// File: rtl/stream_sink_pkg.sv
// Shared definitions for the stream sink: FSM encoding and FIFO entry layout.
package stream_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IN_PKT  = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    // Each FIFO entry is {last, data[7:0]}
    localparam int LAST_BIT = 8;
    localparam int ENTRY_W  = 9;

endpackage

// File: rtl/stream_sink_fifo_mem.sv
// Byte FIFO storage: DEPTH x ENTRY_W register array, one write port,
// one registered read port, plus a combinational peek of the head entry's
// last flag so the packet counter can be adjusted in the same cycle as a pop.
module sink_fifo_mem
    import stream_sink_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               re,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               head_last
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] rd_data_d;
    logic [ENTRY_W-1:0] rd_data_q;

    // Array contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data only changes on a pop and is otherwise held.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign head_last = mem_q[rd_addr][LAST_BIT];

endmodule

// File: rtl/stream_sink.sv
// AXI-Stream byte sink: stores {last, data} beats in a circular FIFO, counts
// stored bytes and complete packets, and truncates packets longer than MAX_PKT.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   ST_IDLE    | no packet in progress
//   ST_IN_PKT  | >=1 byte of current packet stored, tlast not seen
//   ST_DISCARD | dropping the tail of an oversize packet
module stream_sink
    import stream_sink_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_PKT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic                       s_tlast,
    input  logic                       rd_en,
    output logic [7:0]                 dout,
    output logic                       dout_last,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       empty,
    output logic                       full,
    output logic                       len_err,
    output logic [7:0]                 drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PKT);

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   pkt_count_q, pkt_count_d;
    logic [7:0]      pkt_len_q, pkt_len_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            dout_valid_q, dout_valid_d;
    logic            len_err_q, len_err_d;

    logic            accept;
    logic            wr_en;
    logic            wr_last;
    logic            pop;
    logic            head_last;
    logic [7:0]      pkt_len_inc;
    logic [ENTRY_W-1:0] rd_data;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    // DISCARD keeps accepting so an oversize tail never stalls upstream.
    assign s_tready = (state_q == ST_DISCARD) || !full;
    assign accept   = s_tvalid && s_tready;
    assign pop      = rd_en && !empty;

    // Packet FSM: decide whether an accepted beat is stored or dropped.
    always_comb begin
        state_d     = state_q;
        pkt_len_d   = pkt_len_q;
        drop_cnt_d  = drop_cnt_q;
        len_err_d   = 1'b0;
        wr_en       = 1'b0;
        wr_last     = s_tlast;
        pkt_len_inc = pkt_len_q + 8'd1;
        if (accept) begin
            case (state_q)
                ST_IDLE, ST_IN_PKT: begin
                    wr_en = 1'b1;
                    if (s_tlast) begin
                        state_d   = ST_IDLE;
                        pkt_len_d = '0;
                    end else if (pkt_len_inc == MAX_LEN) begin
                        // Close the stored packet here so the reader still sees a boundary.
                        wr_last   = 1'b1;
                        len_err_d = 1'b1;
                        state_d   = ST_DISCARD;
                        pkt_len_d = pkt_len_inc;
                    end else begin
                        state_d   = ST_IN_PKT;
                        pkt_len_d = pkt_len_inc;
                    end
                end
                ST_DISCARD: begin
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                    if (s_tlast) begin
                        state_d   = ST_IDLE;
                        pkt_len_d = '0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    pkt_len_d = '0;
                end
            endcase
        end
    end

    // Pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d     = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        dout_valid_d = pop;
        count_d      = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
        pkt_count_d = pkt_count_q;
        if ((wr_en && wr_last) && !(pop && head_last)) begin
            pkt_count_d = pkt_count_q + CW'(1);
        end else if (!(wr_en && wr_last) && (pop && head_last)) begin
            pkt_count_d = pkt_count_q - CW'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pkt_count_q  <= '0;
            pkt_len_q    <= '0;
            drop_cnt_q   <= '0;
            dout_valid_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pkt_count_q  <= pkt_count_d;
            pkt_len_q    <= pkt_len_d;
            drop_cnt_q   <= drop_cnt_d;
            dout_valid_q <= dout_valid_d;
            len_err_q    <= len_err_d;
        end
    end

    sink_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .we        (wr_en),
        .wr_addr   (wr_ptr_q),
        .wr_data   ({wr_last, s_tdata}),
        .re        (pop),
        .rd_addr   (rd_ptr_q),
        .rd_data   (rd_data),
        .head_last (head_last)
    );

    assign dout       = rd_data[7:0];
    assign dout_last  = rd_data[LAST_BIT];
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign pkt_count  = pkt_count_q;
    assign len_err    = len_err_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_stream_sink.sv
// Bench for stream_sink (DEPTH=16, MAX_PKT=4): a behavioural model with a
// scoreboard queue predicts every output each cycle; a vector table covers
// the basic packet, hand-written sequences cover the multi-cycle cases.
module tb_stream_sink;

    localparam int DEPTH   = 16;
    localparam int MAX_PKT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic       rd_en;
    logic [7:0] dout;
    logic       dout_last;
    logic       dout_valid;
    logic [4:0] count;
    logic [4:0] pkt_count;
    logic       empty;
    logic       full;
    logic       len_err;
    logic [7:0] drop_cnt;

    stream_sink #(.DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .count      (count),
        .pkt_count  (pkt_count),
        .empty      (empty),
        .full       (full),
        .len_err    (len_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_lerr = 0;

    // model state
    logic [8:0] sb[$];
    int         m_state, m_count, m_pkt, m_len, m_drop;
    logic [7:0] m_dout;
    logic       m_dlast, m_dv, m_lerr;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r;
        int         cnt;
        int         pkt;
        logic       dv;
        logic [7:0] dout;
        logic       dl;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_state = 0; m_count = 0; m_pkt = 0; m_len = 0; m_drop = 0;
        m_dout = 8'h00; m_dlast = 1'b0; m_dv = 1'b0; m_lerr = 1'b0;
    endtask

    task automatic check_outputs();
        chk("count", int'(count), m_count);
        chk("pkt_count", int'(pkt_count), m_pkt);
        chk("empty", int'(empty), int'(m_count == 0));
        chk("full", int'(full), int'(m_count == DEPTH));
        chk("dout_valid", int'(dout_valid), int'(m_dv));
        chk("dout", int'(dout), int'(m_dout));
        chk("dout_last", int'(dout_last), int'(m_dlast));
        chk("len_err", int'(len_err), int'(m_lerr));
        chk("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    // One clock: drive inputs, predict, advance, compare.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r);
        logic       rdy, acc, pp;
        logic [8:0] e;
        int         nl;
        s_tvalid = v; s_tdata = d; s_tlast = l; rd_en = r;
        #1;
        rdy = (m_state == 2) || (m_count < DEPTH);
        chk("s_tready", int'(s_tready), int'(rdy));
        acc = v && rdy;
        pp  = r && (m_count != 0);
        m_lerr = 1'b0;
        m_dv   = pp;
        if (pp) begin
            e = sb.pop_front();
            m_dout = e[7:0]; m_dlast = e[8];
            m_count--;
            if (e[8]) m_pkt--;
        end
        if (acc) begin
            if (m_state == 2) begin
                if (m_drop != 255) m_drop++;
                if (l) begin m_state = 0; m_len = 0; end
            end else begin
                nl = m_len + 1;
                m_count++;
                if (l) begin
                    sb.push_back({1'b1, d}); m_pkt++; m_state = 0; m_len = 0;
                end else if (nl == MAX_PKT) begin
                    sb.push_back({1'b1, d}); m_pkt++; m_state = 2; m_len = nl; m_lerr = 1'b1;
                end else begin
                    sb.push_back({1'b0, d}); m_state = 1; m_len = nl;
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
        if (len_err) n_lerr++;
        s_tvalid = 1'b0; rd_en = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && m_count != 0; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("drained_empty", int'(empty), 1);
    endtask

    initial begin
        int idx;
        int len;
        rst = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; rd_en = 1'b0;
        model_reset();

        tbl[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 2, 0, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 8'hA3, 1'b1, 1'b0, 3, 1, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 2, 1, 1'b1, 8'hA1, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1, 1'b1, 8'hA2, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 1'b1, 8'hA3, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 0, 1'b0, 8'hA3, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_s_tready", int'(s_tready), 1);
        rst = 1'b0;

        // basic 3-byte packet, then pops incl. one while empty
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            chk("tbl_count", int'(count), tbl[i].cnt);
            chk("tbl_pkt", int'(pkt_count), tbl[i].pkt);
            chk("tbl_dv", int'(dout_valid), int'(tbl[i].dv));
            chk("tbl_dout", int'(dout), int'(tbl[i].dout));
            chk("tbl_dlast", int'(dout_last), int'(tbl[i].dl));
        end

        // fill to full with 4-byte packets, stall a 17th beat, then release
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), (i % 4) == 3, 1'b0);
        chk("full_flag", int'(full), 1);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("stall_tready", int'(s_tready), 0);
        chk("stall_count", int'(count), DEPTH);
        cycle(1'b1, 8'h55, 1'b1, 1'b1);
        chk("pop_at_full_count", int'(count), DEPTH - 1);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("refill_count", int'(count), DEPTH);
        drain();

        // oversize packet 0x10..0x15 truncated at 4 bytes
        n_lerr = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h10 + i), i == 5, 1'b0);
        chk("trunc_count", int'(count), 4);
        chk("trunc_pkt", int'(pkt_count), 1);
        chk("trunc_drop", int'(drop_cnt), 2);
        chk("trunc_lerr_pulses", n_lerr, 1);
        chk("trunc_state", int'(dut.state_q), 0);
        drain();
        chk("trunc_last_byte", int'(dout), 8'h13);
        chk("trunc_last_flag", int'(dout_last), 1);

        // simultaneous write and pop at count=5
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 1'b1, 1'b0);
        cycle(1'b1, 8'h04, 1'b0, 1'b0);
        cycle(1'b1, 8'h05, 1'b1, 1'b0);
        cycle(1'b1, 8'h06, 1'b1, 1'b1);
        chk("simul_count", int'(count), 5);
        chk("simul_pkt", int'(pkt_count), 3);
        cycle(1'b1, 8'h07, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        chk("simul_pop_last_pkt", int'(pkt_count), 3);
        drain();
        // write and pop while empty: pop ignored, no bypass
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        chk("empty_bypass_dv", int'(dout_valid), 0);
        chk("empty_bypass_count", int'(count), 1);
        drain();

        // 20 packets streamed with continuous pops so pointers wrap
        for (int p = 0; p < 20; p++) begin
            len = (p % MAX_PKT) + 1;
            for (int b = 0; b < len; b++) begin
                idx = $urandom_range(0, 255);
                cycle(1'b1, 8'(idx), (b == len - 1), 1'b1);
            end
        end
        drain();

        // reset mid-packet
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b1);
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs();
        chk("rst_s_tready", int'(s_tready), 1);
        chk("rst_state", int'(dut.state_q), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b1, 1'b0);
        chk("post_rst_pkt", int'(pkt_count), 1);
        drain();
        chk("post_rst_dout", int'(dout), 8'hC2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_sink.md
# stream_sink

AXI-Stream byte receiver that terminates a stream produced by our stream-generator source. It accepts beats over a tvalid/tready/tlast handshake, stores each byte with its last flag in a circular FIFO, and tracks packet boundaries. A pop interface lets the I2C-side logic drain bytes in arrival order; its flow control never needs to see the stream handshake. A small FSM enforces a maximum packet length and discards the overrun tail of oversize packets.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- MAX_PKT, 16, maximum bytes per packet; 1..255
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_tdata  in  8  stream data
- s_tvalid  in  1  stream beat valid
- s_tready  out  1  sink ready; a beat transfers when s_tvalid && s_tready at a rising edge
- s_tlast  in  1  final beat of packet
- rd_en  in  1  pop request
- dout  out  8  popped byte
- dout_last  out  1  popped byte ended its packet
- dout_valid  out  1  one-cycle pulse, dout/dout_last are fresh
- count  out  $clog2(DEPTH)+1  bytes stored, 0..DEPTH
- pkt_count  out  $clog2(DEPTH)+1  complete packets stored (last-flagged entries)
- empty  out  1  count==0
- full  out  1  count==DEPTH
- len_err  out  1  one-cycle pulse, oversize packet truncated
- drop_cnt  out  8  saturating count of beats discarded

## Operation
- Storage: DEPTH×9-bit array {last, data}; wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap naturally; count is kept separately, so full and empty are unambiguous.
- FSM states:
  - IDLE: no packet in progress.
  - IN_PKT: ≥1 byte of the current packet stored, tlast not yet seen.
  - DISCARD: dropping the tail of an oversize packet.
- pkt_len (8 bits) counts the bytes stored for the current packet.
- Beat accepted in IDLE or IN_PKT: write {s_tlast, s_tdata}; pkt_len+1.
  - If s_tlast: go to IDLE and clear pkt_len.
  - Else if the new pkt_len == MAX_PKT: store with last forced to 1, pulse len_err, go to DISCARD.
  - Else: go to IN_PKT.
- DISCARD: s_tready=1 regardless of full; beats are not written and drop_cnt increments (saturating at 255). The beat with s_tlast returns to IDLE and clears pkt_len.
- s_tready = (state==DISCARD) || !full. It is combinational from registered state/count and never depends on s_tvalid.
- Pop: rd_en && !empty reads the rd_ptr entry into dout/dout_last and advances rd_ptr. rd_en while empty is ignored: no pulse, no pointer change.
- count: +1 on write only, −1 on pop only, unchanged on both.
- pkt_count: +1 on a write with stored last=1, −1 on a pop with last=1, unchanged on both.
- Simultaneous write and pop with full=1: the write is blocked because s_tready=0 that cycle; no same-cycle slot reuse.
- Simultaneous write and pop with empty=1: the pop is ignored; no bypass path.

## Timing
- Reset values: state IDLE, pointers 0, count 0, pkt_count 0, pkt_len 0, empty 1, full 0, s_tready 1 (combinational after reset), dout 0, dout_last 0, dout_valid 0, len_err 0, drop_cnt 0.
- Array contents are not reset.
- Write latency: a byte accepted at edge N is visible in count/empty after edge N and can be popped by an rd_en sampled at edge N+1.
- Pop latency: rd_en at edge N gives dout/dout_last/dout_valid valid after edge N, held until the next pop. dout_valid lasts exactly one cycle per pop.
- Back-to-back pops every cycle are supported. Back-to-back beats are accepted every cycle while not full.
- A reset mid-packet discards all contents and partial packet state and returns to IDLE. Upstream must restart its packet.

## Structure
- Shared package holds the FSM state encoding (IDLE=2'd0, IN_PKT=2'd1, DISCARD=2'd2) and the entry layout constants (LAST_BIT=8, ENTRY_W=9).
- One sub-module, sink_fifo_mem: DEPTH×ENTRY_W register array with write port and registered read port.
- FSM, pointers, counters and handshake stay in stream_sink.

## Test plan
- Reset, then 3-byte packet 0xA1,0xA2,0xA3 (tlast on 0xA3), then 3 pops -> count 3, pkt_count 1 before popping; pops return A1/0, A2/0, A3/1; afterwards empty=1, pkt_count=0.
- 16 beats with no pops, 17th beat held valid -> full=1, s_tready=0, 17th byte stays stalled; one pop -> s_tready=1 next cycle, 17th byte accepted, count returns to 16.
- MAX_PKT=4, 6-byte packet 0x10..0x15 -> 4 bytes stored, 0x13 has last=1, len_err pulses once, drop_cnt=2, state IDLE after 0x15.
- Write and pop in the same cycle at count=5 -> count stays 5, pkt_count tracks the last flags; rd_en while empty -> no dout_valid.
- 20 packets through continuous write/pop so pointers wrap -> byte order and last flags preserved end to end.
- rst asserted mid-packet after 2 bytes -> all outputs at reset values; next packet is received cleanly.
